// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: state codes, default parameters
// and the priority next-set-bit search used for EXEC and DISPLAY advancement.
package mode_sequencer_pkg;

  localparam int MAX_MODES              = 8;
  localparam int DEFAULT_NUM_MODES      = 3;
  localparam int DEFAULT_DISP_HOLD      = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SEND    = 3'd2,
    ST_EXEC    = 3'd3,
    ST_DISPLAY = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } next_t;

  // Lowest set bit of mask at or above start; start = MAX_MODES finds nothing.
  function automatic next_t next_set(input logic [MAX_MODES-1:0] mask,
                                     input logic [3:0] start);
    next_t r;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = MAX_MODES - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= start)) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mode_sequencer_watchdog.sv
// Per-state watchdog: counts cycles while active, clears on restart, and
// flags expiry on the TIMEOUT_CYCLES-th cycle. TIMEOUT_CYCLES=0 never expires.
module mode_sequencer_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expired
);

  localparam int  CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit  ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (clear || !active) cnt_q <= '0;
    else if (cnt_q != LAST)   cnt_q <= cnt_q + 1'b1;
  end

  assign expired = ENABLE && active && (cnt_q == LAST);

endmodule

// File: rtl/mode_sequencer.sv
// Run sequencer: CAPTURE -> SEND -> enabled compute modes -> timed DISPLAY walk,
// with a per-state watchdog that traps into a sticky ERROR state.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int NUM_MODES      = DEFAULT_NUM_MODES,
  parameter int DISP_HOLD      = DEFAULT_DISP_HOLD,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int MODE_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [NUM_MODES-1:0] mode_en,
  input  logic                 done_capture,
  input  logic                 done_send,
  input  logic [NUM_MODES-1:0] done_mode,
  output logic                 state_capture,
  output logic                 state_send,
  output logic [NUM_MODES-1:0] state_mode,
  output logic [NUM_MODES-1:0] latch_mode,
  output logic                 state_display,
  output logic [MODE_W-1:0]    disp_sel,
  output logic [2:0]           current_state,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DISP_HOLD - 1);

  state_t                state_q, state_d;
  logic [NUM_MODES-1:0]  en_q, en_d;
  logic [MODE_W-1:0]     cur_q, cur_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  advance;
  logic                  wd_active, wd_expired;
  logic [MAX_MODES-1:0]  en_pad;
  next_t                 first_set, after_cur;

  assign en_pad    = MAX_MODES'(en_q);
  assign first_set = next_set(en_pad, 4'd0);
  assign after_cur = next_set(en_pad, 4'(cur_q) + 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      cur_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    cur_d      = cur_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    advance    = 1'b0;
    latch_mode = '0;
    unique case (state_q)
      ST_IDLE: if (run) begin
        state_d = ST_CAPTURE;
        en_d    = mode_en;
      end
      ST_CAPTURE: begin
        if (done_capture)    state_d = ST_SEND;
        else if (wd_expired) begin state_d = ST_ERROR; err_d = 1'b1; end
      end
      ST_SEND: begin
        if (done_send) begin
          if (first_set.found) begin
            state_d = ST_EXEC;
            cur_d   = MODE_W'(first_set.idx);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      ST_EXEC: begin
        // Only the running mode's done is honoured; other bits are stray.
        if (done_mode[cur_q]) begin
          latch_mode[cur_q] = 1'b1;
          if (after_cur.found) begin
            cur_d   = MODE_W'(after_cur.idx);
            advance = 1'b1;
          end else begin
            state_d = ST_DISPLAY;
            cur_d   = MODE_W'(first_set.idx);
            hold_d  = '0;
          end
        end else if (wd_expired) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (after_cur.found) begin
            cur_d = MODE_W'(after_cur.idx);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_ERROR: if (run) begin
        state_d = ST_CAPTURE;
        en_d    = mode_en;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Advancing to the next mode restarts the timeout just like a state change.
  assign wd_active = (state_q == ST_CAPTURE) || (state_q == ST_SEND) || (state_q == ST_EXEC);

  mode_sequencer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (wd_active),
    .clear  ((state_d != state_q) || advance),
    .expired(wd_expired)
  );

  assign state_capture = (state_q == ST_CAPTURE);
  assign state_send    = (state_q == ST_SEND);
  assign state_mode    = (state_q == ST_EXEC) ? (NUM_MODES'(1) << cur_q) : '0;
  assign state_display = (state_q == ST_DISPLAY);
  assign disp_sel      = state_display ? cur_q : '0;
  assign current_state = state_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor to the fixed capture/send/PE/SA-3x3/SA-2x2/display controller.
- Sequences one run through capture, send, up to NUM_MODES compute modes selected by a per-run enable mask, then a timed display walk over each enabled mode's result.
- Adds a per-state watchdog with a sticky error state.
- Sits between the top-level run input and the memory, core and display blocks; drives their one-hot activate strobes and the 3-bit state code.

Parameters:
- NUM_MODES, 3: number of compute modes (mode 0 = single PE, 1 = SA 3x3, 2 = SA 2x2 in the current top); legal range 1..8.
- DISP_HOLD, 4: cycles each enabled mode's result is shown during DISPLAY; must be at least 1.
- TIMEOUT_CYCLES, 1024: watchdog limit per CAPTURE/SEND/EXEC state; 0 disables the watchdog.
- MODE_W, max(1,clog2(NUM_MODES)): width of mode indices (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- run  in  1  start request, level or pulse; sampled each cycle
- mode_en  in  NUM_MODES  mode enable mask, latched when run is accepted
- done_capture  in  1  memory capture complete
- done_send  in  1  operand send complete
- done_mode  in  NUM_MODES  per-mode compute complete
- state_capture  out  1  high while in CAPTURE
- state_send  out  1  high while in SEND
- state_mode  out  NUM_MODES  one-hot activate of the running mode; zero outside EXEC
- latch_mode  out  NUM_MODES  one-cycle pulse: store the result of mode k
- state_display  out  1  high while in DISPLAY
- disp_sel  out  MODE_W  index of the mode whose result is displayed
- current_state  out  3  IDLE=0, CAPTURE=1, SEND=2, EXEC=3, DISPLAY=4, ERROR=5
- busy  out  1  high in any state other than IDLE and ERROR
- done  out  1  one-cycle pulse on return to IDLE after a complete run
- err  out  1  sticky watchdog error

Behaviour:
- Reset value of every output is 0; state is IDLE; internal mask, counters and mode index are 0. Reset mid-operation aborts to IDLE immediately.
- IDLE: run=1 → CAPTURE next cycle; mode_en is latched into en_q.
- CAPTURE: done_capture → SEND.
- SEND: done_send → EXEC at the lowest set bit of en_q.
  - If en_q is 0, go straight to IDLE and pulse done; DISPLAY is skipped.
- EXEC with cur = k: state_mode = 1<<k.
  - done_mode[k] pulses latch_mode[k] in the same cycle (combinational on done) and advances cur to the next higher set bit of en_q.
  - If there is no higher set bit, go to DISPLAY with disp_sel = lowest set bit of en_q.
  - done_mode bits other than k are ignored.
- DISPLAY: each enabled index is held for exactly DISP_HOLD cycles, ascending, skipping disabled modes. After the last one go to IDLE and pulse done in the IDLE entry cycle.
- Watchdog: a counter clears on every state change.
  - In CAPTURE, SEND or EXEC, if the expected done has not arrived after TIMEOUT_CYCLES cycles in the state, go to ERROR and set err.
  - A done arriving on the expiry cycle wins: no error.
- ERROR: all activates are low and busy=0.
  - run=1 clears err, re-latches mode_en and goes to CAPTURE.
- run is ignored while busy. Transitions take one cycle; outputs are registered from state (Moore), except latch_mode.
- Minimum run latency with all dones arriving on the first active cycle and a single enabled mode: 3 compute cycles + DISP_HOLD display cycles.

Decomposition:
- Shared package: the state encoding constants (3-bit codes above), the default parameter values, and a priority-next-set-bit function used for both EXEC and DISPLAY advancement.
- One sub-module is natural: mode_sequencer_watchdog, holding the counter, the clear-on-state-change logic and the expiry compare, with TIMEOUT_CYCLES=0 as pass-through.

Test Plan:
- Basic run:
  - Stimulus: NUM_MODES=3, mode_en=3'b111, run pulse; each done one cycle after its activate.
  - Required: current_state 1,2,3,3,3,4 then 0; state_mode sequence 001,010,100; latch_mode pulses match; disp_sel 0,1,2, each held 4 cycles; one done pulse.
- Skip modes:
  - Stimulus: mode_en=3'b101.
  - Required: mode 1 never activated; disp_sel shows 0 then 2, for 8 display cycles total.
- Empty mask:
  - Stimulus: mode_en=0.
  - Required: SEND→IDLE with a done pulse; state_display never asserted.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8; withhold done_send.
  - Required: ERROR after exactly 8 SEND cycles, err=1, busy=0. A later run clears err and enters CAPTURE.
  - Also: done_send on cycle 8 avoids the error.
- Glitches:
  - Stimulus: run held high throughout; stray done_mode[2] asserted during mode 0.
  - Required: no restart while busy; stray done ignored; one run completes; a new run starts the cycle after IDLE is re-entered.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously in EXEC mode 1.
  - Required: all outputs 0 immediately, current_state=0; normal run afterwards.
